// File: rtl/event_watcher_if.sv
// event_watcher_if: raw channel inputs, sequencer control and monitor status.
// master drives channels/control, slave is the watcher.
interface event_watcher_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) ();
    localparam int SW = $clog2(CH);

    logic [CH-1:0]       sig_i;
    logic [2*CH-1:0]     mode_i;
    logic                clr_i;
    logic                arm_i;
    logic [3*SW-1:0]     sel_i;
    logic [CH-1:0]       evt_o;
    logic [CH*CNT_W-1:0] cnt_o;
    logic                busy_o;
    logic [1:0]          state_o;
    logic                trig_o;
    logic                tmo_o;

    modport master (
        output sig_i, mode_i, clr_i, arm_i, sel_i,
        input  evt_o, cnt_o, busy_o, state_o, trig_o, tmo_o
    );

    modport slave (
        input  sig_i, mode_i, clr_i, arm_i, sel_i,
        output evt_o, cnt_o, busy_o, state_o, trig_o, tmo_o
    );
endinterface

// File: rtl/event_watcher.sv
// event_watcher: per-channel sync + edge/level detect with saturating counters,
// and a level -> rising edge -> event trigger sequencer with optional timeout.
module event_watcher #(
    parameter int CH    = 4,
    parameter int CNT_W = 8,
    parameter bit SYNC  = 1'b1,
    parameter int TMO   = 0
) (
    input logic            clk,
    input logic            rst_n,
    event_watcher_if.slave bus
);
    localparam int SW = $clog2(CH);
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TMO > 0) ? TMO - 1 : 0);
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LVL  = 2'd1,
        WAIT_EDGE = 2'd2,
        WAIT_EVT  = 2'd3
    } state_t;

    logic [CH-1:0]       s;
    logic [CH-1:0]       prev;
    logic [CH-1:0]       evt;
    logic [CH*CNT_W-1:0] cnt_q;
    state_t              state;
    state_t              nxt;
    logic [SW-1:0]       sel_a;
    logic [SW-1:0]       sel_b;
    logic [SW-1:0]       sel_c;
    logic [TW-1:0]       timer;
    logic                cond;
    logic                fire;
    logic                abort;
    logic                trig_q;
    logic                tmo_q;

    generate
        if (SYNC) begin : g_sync
            logic [CH-1:0] meta;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta <= '0;
                    s    <= '0;
                end else begin
                    meta <= bus.sig_i;
                    s    <= meta;
                end
            end
        end else begin : g_direct
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) s <= '0;
                else        s <= bus.sig_i;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= '0;
        else        prev <= s;
    end

    always_comb begin
        evt = '0;
        for (int i = 0; i < CH; i++) begin
            case (bus.mode_i[2*i +: 2])
                2'b00:   evt[i] = s[i];
                2'b01:   evt[i] = s[i] & ~prev[i];
                2'b10:   evt[i] = ~s[i] & prev[i];
                default: evt[i] = s[i] ^ prev[i];
            endcase
        end
    end

    // Clear has priority; saturated counters hold at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.clr_i) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (evt[i] && cnt_q[i*CNT_W +: CNT_W] != CMAX)
                    cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + 1'b1;
            end
        end
    end

    always_comb begin
        cond = 1'b0;
        case (state)
            WAIT_LVL:  cond = s[sel_a];
            WAIT_EDGE: cond = s[sel_b] & ~prev[sel_b];
            WAIT_EVT:  cond = evt[sel_c];
            default:   cond = 1'b0;
        endcase
    end

    // Re-arm beats everything; a true condition beats the timeout.
    always_comb begin
        nxt   = state;
        fire  = 1'b0;
        abort = 1'b0;
        if (bus.arm_i) begin
            nxt = WAIT_LVL;
        end else if (state != IDLE) begin
            if (cond) begin
                case (state)
                    WAIT_LVL:  nxt = WAIT_EDGE;
                    WAIT_EDGE: nxt = WAIT_EVT;
                    default: begin
                        nxt  = IDLE;
                        fire = 1'b1;
                    end
                endcase
            end else if (TMO > 0 && timer == TLAST) begin
                nxt   = IDLE;
                abort = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel_a  <= '0;
            sel_b  <= '0;
            sel_c  <= '0;
            timer  <= '0;
            trig_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            state  <= nxt;
            trig_q <= fire;
            tmo_q  <= abort;
            if (bus.arm_i) begin
                sel_a <= bus.sel_i[SW-1:0];
                sel_b <= bus.sel_i[2*SW-1:SW];
                sel_c <= bus.sel_i[3*SW-1:2*SW];
            end
            if (bus.arm_i || nxt != state || state == IDLE)
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end

    assign bus.evt_o   = evt;
    assign bus.cnt_o   = cnt_q;
    assign bus.busy_o  = (state != IDLE);
    assign bus.state_o = state;
    assign bus.trig_o  = trig_q;
    assign bus.tmo_o   = tmo_q;
endmodule
